// File: rtl/register_file_sb.sv
// Multi-port architectural register file with write-back bypass and a
// per-register pending-write scoreboard used by issue for RAW/WAW detection.
module register_file_sb #(
  parameter  int REGISTERS  = 32,
  parameter  int WIDTH      = 32,
  parameter  int READ_PORTS = 2,
  localparam int AW         = $clog2(REGISTERS),
  localparam int CW         = $clog2(REGISTERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [READ_PORTS*AW-1:0]     ra,
  output logic [READ_PORTS*WIDTH-1:0]  rd,
  output logic [READ_PORTS-1:0]        rd_ready,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [WIDTH-1:0]             wd,
  input  logic                         alloc_valid,
  input  logic [AW-1:0]                alloc_addr,
  output logic                         alloc_ready,
  input  logic                         flush,
  output logic [CW-1:0]                pending_count
);

  logic [WIDTH-1:0]     regs_q [REGISTERS];
  logic [WIDTH-1:0]     regs_d [REGISTERS];
  logic [REGISTERS-1:0] pending_q, pending_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 wb_en;
  logic                 alloc_fire;

  assign wb_en       = we && (wa != '0);
  assign alloc_ready = !flush && ((alloc_addr == '0) || !pending_q[alloc_addr] ||
                                  (we && (wa == alloc_addr)));
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_addr != '0);

  // Each port resolves x0, then the in-flight write-back, then storage.
  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit_wb;
    assign addr   = ra[i*AW +: AW];
    assign hit_wb = we && (wa == addr);
    assign rd[i*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                  hit_wb       ? wd : regs_q[addr];
    assign rd_ready[i] = (addr == '0) || hit_wb || !pending_q[addr];
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wa] = wd;
  end

  // Allocation is applied after write-back so a same-register pair stays pending.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wb_en)      pending_d[wa]         = 1'b0;
      if (alloc_fire) pending_d[alloc_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      count_d = count_d + CW'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_count = count_q;

endmodule
